load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Responder for the core data-memory interface: accepts core_req/we/size/addr/wd, drives
//  core_stall_o until the access completes, returns sign/zero-extended load data. Master side
//  of a word-wide byte-enabled data-memory bus with ready handshake; sits between core and
//  data memory/peripheral mux. Flags misaligned accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT  16  max cycles in BUSY waiting for mem_ready_i before forcing error completion (>=2)
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_i          in   1   reset, asynchronous, active-high
//  core_req_i     in   1   core requests a memory access this cycle
//  core_we_i      in   1   1 = store, 0 = load
//  core_size_i    in   3   0 B, 1 H, 2 W, 4 BU, 5 HU (lsu_pkg); other codes illegal
//  core_addr_i    in   32  byte address
//  core_wd_i      in   32  store data, right-aligned
//  core_rd_o      out  32  extended load data, valid while state==DONE
//  core_stall_o   out  1   core must hold its request and not advance PC
//  misalign_o     out  1   1-cycle pulse: misaligned/illegal-size request rejected
//  bus_err_o      out  1   1-cycle pulse: TIMEOUT expired
//  mem_req_o      out  1   memory request
//  mem_we_o       out  1   memory write
//  mem_be_o       out  4   byte enables
//  mem_addr_o     out  32  word address ({core_addr_i[31:2],2'b00})
//  mem_wd_o       out  32  lane-replicated store data
//  mem_rd_i       in   32  memory read word
//  mem_ready_i    in   1   memory completes access this cycle
// BEHAVIOUR
//  Reset (async): state=IDLE, timeout counter=0, rdata reg=0; all outputs 0.
//  FSM IDLE/BUSY/DONE:
//   IDLE: core_req_i & legal & aligned -> mem_req_o=1, core_stall_o=1 (comb.); mem_ready_i same
//         cycle -> capture mem_rd_i, DONE; else BUSY. Misaligned (H: addr[0]!=0; W: addr[1:0]!=0)
//         or illegal size -> misalign_o=1, mem_req_o=0, core_stall_o=0, stay IDLE.
//   BUSY: mem_req_o=1, core_stall_o=1, mem_* from registered request (addr/we/be/wd/size
//         latched at IDLE->BUSY; later core input changes ignored). mem_ready_i -> capture, DONE.
//         Counter increments per BUSY cycle; reaching TIMEOUT-1 w/o ready -> bus_err_o=1,
//         rdata reg=0, DONE. Core dropping core_req_i in BUSY (trap) does not abort: wait for
//         ready/timeout, then DONE.
//   DONE: core_stall_o=0, mem_req_o=0, core_rd_o valid; always -> IDLE next cycle. A new
//         core_req_i in DONE is not accepted (core advances this cycle).
//  Min load/store latency: 1 stall cycle + DONE cycle; each extra memory wait adds 1 cycle.
//  Store lanes: B: be=4'b0001<<addr[1:0], wd={4{wd[7:0]}}; H: be=4'b0011<<addr[1:0],
//   wd={2{wd[15:0]}}; W: be=4'hF, wd=wd. Loads: mem_we_o=0, mem_be_o=4'hF.
//  Load extract: byte = rd>>(8*addr[1:0]), half = rd>>(8*addr[1:0]); B/H sign-extend bit 7/15;
//   BU/HU zero-extend; W passthrough. Extension uses latched addr/size and registered rdata.
//  core_rd_o=0 outside DONE. bus_err_o and misalign_o mutually exclusive, 1 cycle each.
//  Reset asserted in BUSY: immediate IDLE, mem_req_o drops without ready; memory must tolerate.
// STRUCTURE
//  lsu_pkg: size codes LDST_B/H/W/BU/HU, lsu_state_t enum {IDLE,BUSY,DONE}.
//  Sub-module lsu_data_align (comb.): store lane replication + be, load extract/extend.
//  Top: FSM, request latch, timeout counter, rdata register.
// TESTING
//  LW addr 0x100, mem_rd 0xDEADBEEF, ready 1st cycle -> stall 1 cycle, core_rd=0xDEADBEEF in DONE.
//  LB addr 0x103, rd 0x80FF_0000 -> core_rd=0xFFFFFF80; LBU same -> 0x00000080; LHU 0x102 -> 0x80FF.
//  SB addr 0x2, wd 0x1234_56AB -> be=4'b0100, mem_wd=0xABABABAB; SH 0x2 -> be 4'b1100, 0x56AB56AB.
//  LW, mem_ready after 3 waits; core changes addr mid-BUSY -> mem_addr_o stays 0x100, 4 stall cycles.
//  LH addr 0x101 -> misalign_o pulse, no mem_req_o, no stall; size 3 -> same.
//  TIMEOUT=16 no ready -> bus_err_o pulse after 16 BUSY cycles, core_rd=0; rst_i mid-BUSY -> all outputs 0 async.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and the legality/alignment rule applied to incoming core requests.
package lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } lsu_state_t;

  // True when the size code is legal and the byte offset suits that size.
  function automatic logic req_ok(input logic [2:0] size, input logic [1:0] off);
    case (size)
      LDST_B, LDST_BU: req_ok = 1'b1;
      LDST_H, LDST_HU: req_ok = ~off[0];
      LDST_W:          req_ok = (off == 2'b00);
      default:         req_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering: store byte-enables and data replication,
// plus load byte/half extraction with sign or zero extension.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wd_o,
  output logic [31:0] rd_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    be_o    = 4'hF;
    wd_o    = wd_i;
    rd_o    = shifted;

    if (we_i) begin
      case (size_i)
        LDST_B, LDST_BU: begin
          be_o = 4'b0001 << offset_i;
          wd_o = {4{wd_i[7:0]}};
        end
        LDST_H, LDST_HU: begin
          be_o = 4'b0011 << offset_i;
          wd_o = {2{wd_i[15:0]}};
        end
        default: begin
          be_o = 4'hF;
          wd_o = wd_i;
        end
      endcase
    end

    case (size_i)
      LDST_B:  rd_o = {{24{shifted[7]}}, shifted[7:0]};
      LDST_BU: rd_o = {24'd0, shifted[7:0]};
      LDST_H:  rd_o = {{16{shifted[15]}}, shifted[15:0]};
      LDST_HU: rd_o = {16'd0, shifted[15:0]};
      default: rd_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Core-side load/store responder: stalls the core while a word-wide memory
// access is in flight, and flags misaligned requests and bus timeouts.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  lsu_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, wd_q;
  logic [2:0]  size_q;
  logic        we_q;
  logic        err_q, err_d;
  logic        latch;

  logic        sel_we;
  logic [2:0]  sel_size;
  logic [31:0] sel_addr, sel_wd;
  logic [3:0]  al_be;
  logic [31:0] al_wd, al_rd;

  // In IDLE the memory side follows the live core request; afterwards it
  // follows the copy latched on acceptance, so core changes are ignored.
  assign sel_we   = (state_q == IDLE) ? core_we_i   : we_q;
  assign sel_size = (state_q == IDLE) ? core_size_i : size_q;
  assign sel_addr = (state_q == IDLE) ? core_addr_i : addr_q;
  assign sel_wd   = (state_q == IDLE) ? core_wd_i   : wd_q;

  lsu_data_align u_align (
    .we_i     (sel_we),
    .size_i   (sel_size),
    .offset_i (sel_addr[1:0]),
    .wd_i     (sel_wd),
    .rdata_i  (rdata_q),
    .be_o     (al_be),
    .wd_o     (al_wd),
    .rd_o     (al_rd)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    err_d        = 1'b0;
    latch        = 1'b0;
    mem_req_o    = 1'b0;
    core_stall_o = 1'b0;
    misalign_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (core_req_i && !rst_i) begin
          if (req_ok(core_size_i, core_addr_i[1:0])) begin
            mem_req_o    = 1'b1;
            core_stall_o = 1'b1;
            latch        = 1'b1;
            cnt_d        = '0;
            if (mem_ready_i) begin
              rdata_d = mem_rd_i;
              state_d = DONE;
            end else begin
              state_d = BUSY;
            end
          end else begin
            misalign_o = 1'b1;
          end
        end
      end
      BUSY: begin
        mem_req_o    = 1'b1;
        core_stall_o = 1'b1;
        if (mem_ready_i) begin
          rdata_d = mem_rd_i;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (latch) begin
        addr_q <= core_addr_i;
        wd_q   <= core_wd_i;
        size_q <= core_size_i;
        we_q   <= core_we_i;
      end
    end
  end

  // The timeout flag is registered so its pulse lines up with the DONE cycle.
  assign bus_err_o  = err_q;
  assign core_rd_o  = (state_q == DONE) ? al_rd : '0;
  assign mem_we_o   = mem_req_o & sel_we;
  assign mem_be_o   = mem_req_o ? al_be : 4'h0;
  assign mem_addr_o = mem_req_o ? {sel_addr[31:2], 2'b00} : '0;
  assign mem_wd_o   = mem_req_o ? al_wd : '0;

endmodule
